// File: rtl/esc_reg_bank_n.sv
// Multi-channel shadow/live register bank for the I2C byte interface.
// Define ESC_REGS_BROADCAST_EN to make channel index 15 a broadcast address.
module esc_reg_bank_n #(
  parameter int unsigned NCH            = 2,
  parameter logic [15:0] PWM_PERIOD_RST = 16'd1000,
  parameter logic [15:0] PERIOD_REF_RST = 16'd0,
  parameter logic [7:0]  KP_RST         = 8'd4,
  parameter logic [7:0]  KI_RST         = 8'd1,
  parameter logic [6:0]  KD_RST         = 7'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read_1,
  input  logic [7:0]        index_1,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out_1,
  input  logic [8*NCH-1:0]  Kp_int_i,
  output logic [16*NCH-1:0] pwm_period,
  output logic [16*NCH-1:0] period_reference,
  output logic [8*NCH-1:0]  Kp_ext,
  output logic [8*NCH-1:0]  Ki_ext,
  output logic [7*NCH-1:0]  Kd_ext,
  output logic [NCH-1:0]    override_internal_pid,
  output logic [4*NCH-1:0]  tunerreset_autotune,
  output logic [NCH-1:0]    commit_pulse
);

  logic [3:0]            w_ch;
  logic [3:0]            w_off;
  logic                  w_bcast;
  logic                  w_shadow_wr;
  logic                  w_commit;
  logic [NCH-1:0][7:0]   w_rd_ch;
  logic [7:0]            w_rdata;
  logic [7:0]            r_data_out;

  assign w_ch        = index_1[7:4];
  assign w_off       = index_1[3:0];
  assign w_shadow_wr = write && !w_off[3];
  assign w_commit    = write && (w_off == 4'd14) && data_in[0];

`ifdef ESC_REGS_BROADCAST_EN
  assign w_bcast = (w_ch == 4'hF);
`else
  assign w_bcast = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : ch_g
    localparam logic [3:0] CH = 4'(g);

    logic        w_hit;
    logic [7:0]  w_rd;
    logic [15:0] r_sh_pwm, r_sh_ref, r_lv_pwm, r_lv_ref;
    logic [7:0]  r_sh_kp, r_sh_ki, r_lv_kp, r_lv_ki;
    logic [6:0]  r_sh_kd, r_lv_kd;
    logic        r_sh_ovr, r_lv_ovr;
    logic [3:0]  r_sh_tune, r_lv_tune;
    logic        r_pending;
    logic        r_pulse;

    assign w_hit = w_bcast || (w_ch == CH);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sh_pwm  <= PWM_PERIOD_RST;
        r_sh_ref  <= PERIOD_REF_RST;
        r_sh_kp   <= KP_RST;
        r_sh_ki   <= KI_RST;
        r_sh_kd   <= KD_RST;
        r_sh_ovr  <= 1'b0;
        r_sh_tune <= '0;
        r_lv_pwm  <= PWM_PERIOD_RST;
        r_lv_ref  <= PERIOD_REF_RST;
        r_lv_kp   <= KP_RST;
        r_lv_ki   <= KI_RST;
        r_lv_kd   <= KD_RST;
        r_lv_ovr  <= 1'b0;
        r_lv_tune <= '0;
        r_pending <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (w_hit && w_shadow_wr) begin
          r_pending <= 1'b1;
          case (w_off[2:0])
            3'd0: r_sh_pwm[7:0]  <= data_in;
            3'd1: r_sh_pwm[15:8] <= data_in;
            3'd2: r_sh_ref[7:0]  <= data_in;
            3'd3: r_sh_ref[15:8] <= data_in;
            3'd4: r_sh_kp        <= data_in;
            3'd5: r_sh_ki        <= data_in;
            3'd6: r_sh_kd        <= data_in[6:0];
            default: begin
              r_sh_ovr  <= data_in[0];
              r_sh_tune <= data_in[7:4];
            end
          endcase
        end
        if (w_hit && w_commit) begin
          r_lv_pwm  <= r_sh_pwm;
          r_lv_ref  <= r_sh_ref;
          r_lv_kp   <= r_sh_kp;
          r_lv_ki   <= r_sh_ki;
          r_lv_kd   <= r_sh_kd;
          r_lv_ovr  <= r_sh_ovr;
          r_lv_tune <= r_sh_tune;
          r_pending <= 1'b0;
          r_pulse   <= 1'b1;
        end
      end
    end

    always_comb begin
      w_rd = '0;
      case (w_off)
        4'd0:    w_rd = r_sh_pwm[7:0];
        4'd1:    w_rd = r_sh_pwm[15:8];
        4'd2:    w_rd = r_sh_ref[7:0];
        4'd3:    w_rd = r_sh_ref[15:8];
        4'd4:    w_rd = r_sh_kp;
        4'd5:    w_rd = r_sh_ki;
        4'd6:    w_rd = {1'b0, r_sh_kd};
        4'd7:    w_rd = {r_sh_tune, 3'b000, r_sh_ovr};
        4'd8:    w_rd = Kp_int_i[8*g +: 8];
        4'd9:    w_rd = {7'd0, r_pending};
        default: w_rd = '0;
      endcase
    end

    assign w_rd_ch[g]                   = w_rd;
    assign pwm_period[16*g +: 16]       = r_lv_pwm;
    assign period_reference[16*g +: 16] = r_lv_ref;
    assign Kp_ext[8*g +: 8]             = r_lv_kp;
    assign Ki_ext[8*g +: 8]             = r_lv_ki;
    assign Kd_ext[7*g +: 7]             = r_lv_kd;
    assign override_internal_pid[g]     = r_lv_ovr;
    assign tunerreset_autotune[4*g +: 4] = r_lv_tune;
    assign commit_pulse[g]              = r_pulse;
  end

  // Broadcast and out-of-range channels match no channel and read as zero.
  always_comb begin
    w_rdata = '0;
    if (!w_bcast) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (w_ch == 4'(c)) w_rdata = w_rd_ch[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_data_out <= '0;
    else if (read_1 && !write) r_data_out <= w_rdata;
  end

  assign data_out_1 = r_data_out;

endmodule

// File: tb/tb_esc_reg_bank_n.sv
// Self-checking bench for esc_reg_bank_n (NCH=2): vector table, corner sequences, random ops vs byte-level model.
module tb_esc_reg_bank_n;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              write, read_1;
  logic [7:0]        index_1, data_in;
  logic [7:0]        data_out_1;
  logic [8*NCH-1:0]  Kp_int_i;
  logic [16*NCH-1:0] pwm_period, period_reference;
  logic [8*NCH-1:0]  Kp_ext, Ki_ext;
  logic [7*NCH-1:0]  Kd_ext;
  logic [NCH-1:0]    override_internal_pid;
  logic [4*NCH-1:0]  tunerreset_autotune;
  logic [NCH-1:0]    commit_pulse;

  esc_reg_bank_n #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .write(write), .read_1(read_1),
    .index_1(index_1), .data_in(data_in), .data_out_1(data_out_1),
    .Kp_int_i(Kp_int_i), .pwm_period(pwm_period),
    .period_reference(period_reference), .Kp_ext(Kp_ext), .Ki_ext(Ki_ext),
    .Kd_ext(Kd_ext), .override_internal_pid(override_internal_pid),
    .tunerreset_autotune(tunerreset_autotune), .commit_pulse(commit_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: every register is a byte at its offset; live set is a byte copy of shadow.
  logic [7:0]     m_sh [NCH][8];
  logic [7:0]     m_lv [NCH][8];
  logic           m_pend [NCH];
  logic [NCH-1:0] m_pulse;
  logic [7:0]     m_dout;

  function automatic logic [7:0] def_byte(int off);
    case (off)
      0: return 8'hE8;
      1: return 8'h03;
      4: return 8'h04;
      5: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] wmask(int off);
    if (off == 6) return 8'h7F;
    if (off == 7) return 8'hF1;
    return 8'hFF;
  endfunction

  function automatic bit is_bcast(int ch);
`ifdef ESC_REGS_BROADCAST_EN
    return ch == 15;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int o = 0; o < 8; o++) begin
        m_sh[c][o] = def_byte(o);
        m_lv[c][o] = def_byte(o);
      end
      m_pend[c] = 1'b0;
    end
    m_pulse = '0;
    m_dout  = 8'h00;
  endtask

  task automatic m_step(input logic wr, input logic rd, input logic [7:0] idx, input logic [7:0] din);
    int ch, off;
    ch = int'(idx[7:4]);
    off = int'(idx[3:0]);
    m_pulse = '0;
    if (wr) begin
      for (int c = 0; c < NCH; c++) begin
        if (is_bcast(ch) || ch == c) begin
          if (off < 8) begin
            m_sh[c][off] = din & wmask(off);
            m_pend[c] = 1'b1;
          end else if (off == 14 && din[0]) begin
            for (int o = 0; o < 8; o++) m_lv[c][o] = m_sh[c][o];
            m_pend[c] = 1'b0;
            m_pulse[c] = 1'b1;
          end
        end
      end
    end else if (rd) begin
      m_dout = 8'h00;
      if (!is_bcast(ch) && ch < NCH) begin
        if (off < 8)       m_dout = m_sh[ch][off];
        else if (off == 8) m_dout = Kp_int_i[8*ch +: 8];
        else if (off == 9) m_dout = {7'd0, m_pend[ch]};
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [16*NCH-1:0] e_pwm, e_ref;
    logic [8*NCH-1:0]  e_kp, e_ki;
    logic [7*NCH-1:0]  e_kd;
    logic [NCH-1:0]    e_ovr;
    logic [4*NCH-1:0]  e_tune;
    for (int c = 0; c < NCH; c++) begin
      e_pwm[16*c +: 16] = {m_lv[c][1], m_lv[c][0]};
      e_ref[16*c +: 16] = {m_lv[c][3], m_lv[c][2]};
      e_kp[8*c +: 8]    = m_lv[c][4];
      e_ki[8*c +: 8]    = m_lv[c][5];
      e_kd[7*c +: 7]    = m_lv[c][6][6:0];
      e_ovr[c]          = m_lv[c][7][0];
      e_tune[4*c +: 4]  = m_lv[c][7][7:4];
    end
    chk("data_out_1", data_out_1, m_dout);
    chk("pwm_period", pwm_period, e_pwm);
    chk("period_reference", period_reference, e_ref);
    chk("Kp_ext", Kp_ext, e_kp);
    chk("Ki_ext", Ki_ext, e_ki);
    chk("Kd_ext", Kd_ext, e_kd);
    chk("override_internal_pid", override_internal_pid, e_ovr);
    chk("tunerreset_autotune", tunerreset_autotune, e_tune);
    chk("commit_pulse", commit_pulse, m_pulse);
  endtask

  task automatic op(input logic wr, input logic rd, input logic [7:0] idx, input logic [7:0] din);
    @(negedge clk);
    write = wr; read_1 = rd; index_1 = idx; data_in = din;
    @(posedge clk);
    m_step(wr, rd, idx, din);
    #1;
    write = 1'b0; read_1 = 1'b0;
    check_all();
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] idx;
    logic [7:0] din;
    logic       chk_rd;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt.push_back('{0, 1, 8'h00, 8'h00, 1, 8'hE8});
    vt.push_back('{0, 1, 8'h01, 8'h00, 1, 8'h03});
    vt.push_back('{0, 1, 8'h14, 8'h00, 1, 8'h04});
    vt.push_back('{0, 1, 8'h15, 8'h00, 1, 8'h01});
    vt.push_back('{1, 0, 8'h12, 8'h34, 0, 8'h00});
    vt.push_back('{1, 0, 8'h13, 8'h12, 0, 8'h00});
    vt.push_back('{0, 1, 8'h19, 8'h00, 1, 8'h01});
    vt.push_back('{0, 1, 8'h09, 8'h00, 1, 8'h00});
    vt.push_back('{0, 1, 8'h18, 8'h00, 1, 8'hA5});
    vt.push_back('{0, 1, 8'h08, 8'h00, 1, 8'h5A});
    vt.push_back('{0, 1, 8'h50, 8'h00, 1, 8'h00});
    vt.push_back('{1, 0, 8'h50, 8'h77, 0, 8'h00});
    vt.push_back('{0, 1, 8'h0A, 8'h00, 1, 8'h00});
    vt.push_back('{1, 0, 8'h06, 8'hFF, 0, 8'h00});
    vt.push_back('{0, 1, 8'h06, 8'h00, 1, 8'h7F});
    vt.push_back('{1, 1, 8'h07, 8'hFF, 1, 8'h7F});
    vt.push_back('{0, 1, 8'h07, 8'h00, 1, 8'hF1});
    vt.push_back('{1, 0, 8'h0E, 8'h00, 0, 8'h00});
    vt.push_back('{0, 1, 8'h0E, 8'h00, 1, 8'h00});
    vt.push_back('{0, 1, 8'hF4, 8'h00, 1, 8'h00});

    rst = 1'b1; write = 1'b0; read_1 = 1'b0; index_1 = '0; data_in = '0;
    Kp_int_i = 16'hA55A;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;

    foreach (vt[i]) begin
      op(vt[i].wr, vt[i].rd, vt[i].idx, vt[i].din);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_read", i), data_out_1, vt[i].exp);
    end

    chk("ref_ch1_before_commit", period_reference[31:16], 16'h0000);
    op(1, 0, 8'h1E, 8'h01);
    chk("ref_ch1_commit", period_reference[31:16], 16'h1234);
    chk("pulse_ch1_commit", commit_pulse, 2'b10);
    op(0, 1, 8'h19, 8'h00);
    chk("pulse_ch1_after", commit_pulse, 2'b00);
    chk("status_ch1_cleared", data_out_1, 8'h00);

    op(1, 0, 8'h0E, 8'h01);
    chk("kd_ch0_commit", Kd_ext[6:0], 7'h7F);
    chk("ovr_ch0_commit", override_internal_pid[0], 1'b1);
    chk("tune_ch0_commit", tunerreset_autotune[3:0], 4'hF);
    chk("pulse_ch0_commit", commit_pulse, 2'b01);

    op(1, 0, 8'hF4, 8'h20);
    op(1, 0, 8'hFE, 8'h01);
`ifdef ESC_REGS_BROADCAST_EN
    chk("bcast_kp", Kp_ext, 16'h2020);
    chk("bcast_pulse", commit_pulse, 2'b11);
`else
    chk("ch15_kp_unchanged", Kp_ext, 16'h0404);
    chk("ch15_pulse_none", commit_pulse, 2'b00);
`endif

    op(1, 0, 8'h00, 8'h55);
    @(posedge clk);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    op(0, 1, 8'h00, 8'h00);
    chk("rst_shadow_pwm_lo", data_out_1, 8'hE8);
    op(0, 1, 8'h09, 8'h00);
    chk("rst_pending", data_out_1, 8'h00);
    chk("rst_pulse", commit_pulse, 2'b00);

    for (int n = 0; n < 600; n++) begin
      int r, ch, off;
      logic wr, rd;
      Kp_int_i = 16'($urandom);
      r = int'($urandom_range(0, 9));
      ch = (r < 4) ? 0 : (r < 7) ? 1 : (r == 7) ? 15 :
           (r == 8) ? int'($urandom_range(2, 14)) : int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      off = (r < 6) ? int'($urandom_range(0, 7)) : (r < 8) ? 14 :
            (r == 8) ? int'($urandom_range(8, 9)) : int'($urandom_range(0, 15));
      wr = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 59) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
      end
      op(wr, rd, {4'(ch), 4'(off)}, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/esc_reg_bank_n.md
# esc_reg_bank_n

Parametrised multi-channel register bank between the I2C slave byte interface and NCH motor-control channels. Each channel's PID/PWM settings go through shadow registers and are applied atomically on a commit. A commit can target one channel or, through an optional broadcast address, all channels in the same cycle, so several motors change setpoint together. Per-channel live status (internal Kp) is read back over the same byte interface.

## Interface
Parameters:
- NCH, 2: channel count; 1..15 with broadcast compiled in, 1..16 without.
- PWM_PERIOD_RST, 16'd1000: reset value of pwm_period.
- PERIOD_REF_RST, 16'd0: reset value of period_reference.
- KP_RST / KI_RST, 8'd4 / 8'd1: reset values of Kp_ext / Ki_ext.
- KD_RST, 7'd0: reset value of Kd_ext.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- write  in  1  byte-write strobe from I2C slave, one cycle.
- read_1  in  1  byte-read strobe, one cycle.
- index_1  in  8  address: [7:4] channel, [3:0] register offset.
- data_in  in  8  write data.
- data_out_1  out  8  registered read data.
- Kp_int_i  in  8*NCH  live internal Kp per channel; channel c at [8c+7:8c].
- pwm_period  out  16*NCH  live PWM period per channel.
- period_reference  out  16*NCH  live speed reference per channel.
- Kp_ext, Ki_ext  out  8*NCH  live external gains.
- Kd_ext  out  7*NCH  live external Kd.
- override_internal_pid  out  NCH  live override bit per channel.
- tunerreset_autotune  out  4*NCH  live tuner control per channel.
- commit_pulse  out  NCH  one-cycle pulse per channel when its live set updates.

## Operation
- Per-channel register offsets: 0/1 pwm_period lo/hi; 2/3 period_reference lo/hi; 4 Kp_ext; 5 Ki_ext; 6 Kd_ext (data bit7 ignored, reads 0); 7 ctrl (bit0 override, bits[7:4] tunerreset_autotune, bits[3:1] read 0); 8 Kp_int (read-only, live Kp_int_i); 9 status (read-only, bit0 pending); 14 commit (write with data[0]=1 commits; data[0]=0 no effect; reads 0).
- Offsets 0–7 write the shadow set only. Live outputs never change on an ordinary write.
- Commit copies all eight shadow bytes of the channel to its live outputs in one edge, clears pending and pulses commit_pulse[c].
- Pending is set by any write to offsets 0–7 and cleared by commit or reset. A shadow write in the same cycle as a commit cannot occur, because the byte interface carries a single operation per cycle.
- Reads of offsets 0–7 return the shadow value, so software can verify before committing.
- Channel index ≥ NCH (other than broadcast): writes ignored, reads return 0x00. Unmapped offsets 10–13 and 15 behave the same. Writes to offsets 8 and 9 are ignored.
- write and read_1 in the same cycle: the write is performed and data_out_1 holds its previous value.

## Timing
- Reset (async assert): shadow and live sets return to parameter defaults; override = 0; tunerreset_autotune = 0; pending = 0; commit_pulse = 0; data_out_1 = 0x00.
- Write at edge t: shadow updated at t and visible to a read issued at t+1.
- Commit at edge t: live outputs updated at t. commit_pulse[c] is high for exactly the cycle after t.
- Read at edge t: data_out_1 valid from t until the next read. Latency is one cycle.
- Kp_int read samples Kp_int_i at the read edge. There is no extra synchroniser.
- Reset asserted mid-transaction: everything returns to defaults immediately. A half-written 16-bit shadow pair is discarded.

## Configuration
- ESC_REGS_BROADCAST_EN defined: channel index 15 is the broadcast address (requires NCH ≤ 15).
  - A write to offsets 0–7 at channel 15 updates the same shadow byte in every channel and sets every pending bit.
  - A commit at channel 15 commits all channels in the same edge, and all commit_pulse bits assert together.
  - Reads at channel 15 return 0x00.
- ESC_REGS_BROADCAST_EN undefined: channel 15 is an ordinary channel when NCH = 16, and out of range otherwise.

## Test plan
- Reset with NCH=2: read ch0 offset 0/1 -> 0xE8/0x03; ch1 offset 4 -> 0x04; all commit_pulse 0; data_out_1 0x00.
- Write ch1 offsets 2/3 = 0x34/0x12 -> period_reference[31:16] stays 0x0000; ch1 status reads 0x01. Then write ch1 offset 14 = 0x01 -> period_reference[31:16] = 0x1234 at that edge, commit_pulse = 2'b10 for one cycle, status reads 0x00.
- Broadcast (macro on): write ch15 offset 4 = 0x20, then ch15 offset 14 = 0x01 -> Kp_ext = 16'h2020 in the same cycle; commit_pulse = 2'b11.
- Drive Kp_int_i = 16'hA55A and read ch1 offset 8 -> 0xA5. Read ch5 offset 0 -> 0x00. Write ch5 -> no state change.
- Write ch0 offset 6 = 0xFF and commit -> Kd_ext[6:0] = 7'h7F; read back -> 0x7F.
- Write ch0 offset 0 = 0x55, assert rst before commit -> shadow pwm_period returns to 0x03E8; pending = 0; no commit_pulse.
